alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 8-bit unsigned multiply sequencer that drives the combinational ALU through a shift-and-add loop. It uses only ADD, LSH and RSH.
- It sits between the control unit and the ALU operand/opcode muxes, and owns the ALU while Busy is high.
- The result is the low W bits of A×B (modular, wraps).
- The loop terminates early once the multiplier has been fully consumed.

## Interface
- W, 8, datapath width; ALU operand and result width.
- Ops, 4, ALU opcode width; opcode values are ADD, LSH, RSH from the definitions package.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- OpA  input  W  multiplicand; captured on an accepted Start.
- OpB  input  W  multiplier; captured on an accepted Start.
- Busy  output  1  high in ADD, SHL, SHR states.
- Done  output  1  one-cycle pulse in DONE state.
- Product  output  W  registered result; held until the next DONE.
- AluA  output  W  ALU InputA drive.
- AluB  output  W  ALU InputB drive.
- AluOp  output  Ops  ALU OP drive.
- AluOut  input  W  ALU Out.
- AluZero  input  1  ALU Zero flag.

## Operation
- Registers:
  - acc (W): accumulator.
  - mcand (W): multiplicand.
  - mplr (W): multiplier.
  - iter (4 bits): iteration counter.
  - Product (W): result.
  - state: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - ALU drive is AluA=0, AluB=0, AluOp=ADD.
  - On Start=1: load acc=0, mcand=OpA, mplr=OpB, iter=0; go to ADD.
  - On Start=0: stay in IDLE.
- ADD:
  - Drive AluA=acc, AluB=mcand, AluOp=ADD.
  - If mplr[0]=1, acc<=AluOut (modulo 2^W); otherwise acc holds.
  - Next state is SHL.
- SHL:
  - Drive AluA=mcand, AluB=0, AluOp=LSH; mcand<=AluOut.
  - Next state is SHR.
- SHR:
  - Drive AluA=mplr, AluB=0, AluOp=RSH; mplr<=AluOut; iter<=iter+1.
  - If AluZero=1 or iter==W-1, go to DONE and load Product<=acc.
  - Otherwise go to ADD.
- DONE:
  - Done=1 for this single cycle; ALU drive is the same as IDLE.
  - Next state is IDLE unconditionally.
- Start is ignored in ADD, SHL, SHR and DONE. A Start asserted in DONE is not queued.
- OpA and OpB changes after acceptance have no effect.
- B=0 still runs one full ADD/SHL/SHR iteration and yields Product=0.
- The ALU is combinational, so AluOut is consumed in the same cycle the drive is presented.

## Timing
- Reset values:
  - state=IDLE, Busy=0, Done=0, Product=0.
  - acc=0, mcand=0, mplr=0, iter=0.
  - AluA=0, AluB=0, AluOp=ADD.
- Start is accepted at edge 0. ADD, SHL, SHR then occupy cycles 1, 2, 3 for the first iteration and repeat every 3 cycles.
- k = max(1, position of the highest set bit of OpB, 1-based).
- DONE occupies cycle 3k+1:
  - Minimum latency is 4 cycles (OpB ∈ {0,1}).
  - Maximum latency is 25 cycles (OpB[7]=1).
- Product becomes valid in the DONE cycle and is stable until the next DONE.
- The earliest next acceptance is at the end of the IDLE cycle following DONE.
- Reset asserted in any state, including mid-iteration: the next cycle is IDLE with all reset values. The partial result is discarded and no Done pulse is issued.
- Busy and Done are never high in the same cycle.

## Test plan
- Reset, then OpA=3, OpB=5, pulse Start -> Busy for 9 cycles; Done at cycle 10; Product=15.
- OpA=7, OpB=0 -> Done at cycle 4; Product=0.
- OpA=0x10, OpB=0x10 -> Done at cycle 16; Product=0x00 (wrap).
- OpA=0xFF, OpB=0xFF -> Done at cycle 25; Product=0x01.
- OpA=2, OpB=3, then Start re-pulsed at cycles 2 and 7 with OpA=9, OpB=9 -> re-pulses ignored; Done at cycle 7; Product=6. Then Start with 9×9 -> Product=81.
- Start OpA=5, OpB=0x80; assert Reset at cycle 6 -> cycle 7 shows Busy=0, Done=0, Product=0. No Done appears; the next Start works normally.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// Shared opcode/width definitions and the bundle between the multiply sequencer,
// its controller and the combinational ALU it borrows while busy.
package alu_defs_pkg;
  localparam int W   = 8;
  localparam int Ops = 4;

  localparam logic [Ops-1:0] ADD = 4'b0000;
  localparam logic [Ops-1:0] LSH = 4'b0100;
  localparam logic [Ops-1:0] RSH = 4'b0101;
endpackage

interface alu_mul_seq_if;
  logic                          start;
  logic [alu_defs_pkg::W-1:0]    opA;
  logic [alu_defs_pkg::W-1:0]    opB;
  logic                          busy;
  logic                          done;
  logic [alu_defs_pkg::W-1:0]    product;
  logic [alu_defs_pkg::W-1:0]    aluA;
  logic [alu_defs_pkg::W-1:0]    aluB;
  logic [alu_defs_pkg::Ops-1:0]  aluOp;
  logic [alu_defs_pkg::W-1:0]    aluOut;
  logic                          aluZero;

  // The sequencer is the slave; whoever supplies requests and the ALU result is master.
  modport slave (
    input  start, opA, opB, aluOut, aluZero,
    output busy, done, product, aluA, aluB, aluOp
  );

  modport master (
    output start, opA, opB, aluOut, aluZero,
    input  busy, done, product, aluA, aluB, aluOp
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that reuses the shared ALU (ADD/LSH/RSH only),
// stopping as soon as the remaining multiplier bits are all zero.
module alu_mul_seq (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_mul_seq_if.slave  bus
);
  localparam int W   = alu_defs_pkg::W;
  localparam int Ops = alu_defs_pkg::Ops;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic [3:0]     iter_q, iter_d;
  logic [W-1:0]   product_q, product_d;

  logic [W-1:0]   aluA;
  logic [W-1:0]   aluB;
  logic [Ops-1:0] aluOp;
  logic           busy;
  logic           done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      iter_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      iter_q    <= iter_d;
      product_q <= product_d;
    end
  end

  // The ALU result is consumed in the same cycle its operands are presented.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    iter_d    = iter_q;
    product_d = product_q;
    aluA      = '0;
    aluB      = '0;
    aluOp     = alu_defs_pkg::ADD;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          mcand_d = bus.opA;
          mplr_d  = bus.opB;
          iter_d  = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        busy  = 1'b1;
        aluA  = acc_q;
        aluB  = mcand_q;
        aluOp = alu_defs_pkg::ADD;
        if (mplr_q[0]) begin
          acc_d = bus.aluOut;
        end
        state_d = S_SHL;
      end

      S_SHL: begin
        busy    = 1'b1;
        aluA    = mcand_q;
        aluOp   = alu_defs_pkg::LSH;
        mcand_d = bus.aluOut;
        state_d = S_SHR;
      end

      S_SHR: begin
        busy   = 1'b1;
        aluA   = mplr_q;
        aluOp  = alu_defs_pkg::RSH;
        mplr_d = bus.aluOut;
        iter_d = iter_q + 4'd1;
        // A zero shifted multiplier means no further partial products can contribute.
        if (bus.aluZero || (iter_q == 4'(W - 1))) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.aluA    = aluA;
  assign bus.aluB    = aluB;
  assign bus.aluOp   = aluOp;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: a bench-side ALU, a cycle-level reference model
// of the multiply transaction, and per-vector hand-computed results and latencies.
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst;

  int vectorsApplied = 0;
  int miscompares    = 0;
  bit checkEn        = 1'b0;

  always #5 clk = ~clk;

  alu_mul_seq_if bus();

  alu_mul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Combinational ALU: shifts move by one bit position.
  always_comb begin
    case (bus.aluOp)
      alu_defs_pkg::ADD: bus.aluOut = bus.aluA + bus.aluB;
      alu_defs_pkg::LSH: bus.aluOut = bus.aluA << 1;
      alu_defs_pkg::RSH: bus.aluOut = bus.aluA >> 1;
      default:           bus.aluOut = '0;
    endcase
  end
  assign bus.aluZero = (bus.aluOut == '0);

  // Reference: a transaction lasts 3k+1 cycles, k = max(1, index of top set bit of B).
  bit         mActive;
  int         mCyc;
  int         mLast;
  logic [7:0] mProd;
  logic [7:0] mPend;

  function automatic int itersFor(input logic [7:0] b);
    int k = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) k = i + 1;
    end
    return k;
  endfunction

  function automatic logic [7:0] lowProduct(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] full;
    full = 16'(a) * 16'(b);
    return full[7:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mActive <= 1'b0;
      mCyc    <= 0;
      mProd   <= '0;
    end else if (mActive) begin
      mCyc <= mCyc + 1;
      if (mCyc + 1 == mLast) mProd <= mPend;
      if (mCyc + 1 > mLast)  mActive <= 1'b0;
    end else if (bus.start) begin
      mActive <= 1'b1;
      mCyc    <= 1;
      mLast   <= 3 * itersFor(bus.opB) + 1;
      mPend   <= lowProduct(bus.opA, bus.opB);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin : compare
      bit expBusy;
      bit expDone;
      expBusy = mActive && (mCyc < mLast);
      expDone = mActive && (mCyc == mLast);
      checkOutput("busy", 32'(bus.busy), 32'(expBusy));
      checkOutput("done", 32'(bus.done), 32'(expDone));
      checkOutput("product", 32'(bus.product), 32'(mProd));
      if (!expBusy) begin
        checkOutput("idleAluOp", 32'(bus.aluOp), 32'(alu_defs_pkg::ADD));
        checkOutput("idleAluA", 32'(bus.aluA), 32'h0);
        checkOutput("idleAluB", 32'(bus.aluB), 32'h0);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] expProd, input int expCycle);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opA   = a;
    bus.opB   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.opA   = ~a;
    bus.opB   = ~b;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("doneCycle %0d*%0d", a, b), 32'(cyc), 32'(expCycle));
    checkOutput($sformatf("product %0d*%0d", a, b), 32'(bus.product), 32'(expProd));
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opA   = '0;
    bus.opB   = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    checkOutput("resetDone", 32'(bus.done), 32'h0);
    checkOutput("resetProduct", 32'(bus.product), 32'h0);
    checkOutput("resetAluOp", 32'(bus.aluOp), 32'(alu_defs_pkg::ADD));
    rst = 1'b0;

    applyStimulus(8'd3,   8'd5,   8'd15,  10);
    applyStimulus(8'd7,   8'd0,   8'd0,   4);
    applyStimulus(8'd13,  8'd1,   8'd13,  4);
    applyStimulus(8'h10,  8'h10,  8'h00,  16);
    applyStimulus(8'hFF,  8'hFF,  8'h01,  25);

    // Start re-pulsed while busy (cycle 2) and in DONE (cycle 7) must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.opA = 8'd2; bus.opB = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.opA = 8'd9; bus.opB = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("repulseDone7", 32'(bus.done), 32'h1);
    checkOutput("repulseProduct", 32'(bus.product), 32'd6);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("notQueuedBusy9", 32'(bus.busy), 32'h0);
    applyStimulus(8'd9, 8'd9, 8'd81, 13);

    // Reset mid-iteration discards the partial result and suppresses Done.
    @(negedge clk);
    bus.start = 1'b1; bus.opA = 8'd5; bus.opB = 8'h80;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetBusy", 32'(bus.busy), 32'h0);
    checkOutput("midResetDone", 32'(bus.done), 32'h0);
    checkOutput("midResetProduct", 32'(bus.product), 32'h0);
    repeat (30) @(negedge clk);
    applyStimulus(8'd6, 8'd7, 8'd42, 10);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
